// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter: round-robin arbiter sharing one four-phase CDC handshake channel, with ack timeout abort
module cdc_hs_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_src,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic                      ack_sync,
  output logic                      xfer_req,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic [NUM_REQ-1:0]        done_out,
  output logic                      err_out,
  output logic                      busy
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO, ABORT} state_t;
  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, win;
  logic                found, tmo, xreq_q, err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  assign tmo = cnt_q == 16'(TIMEOUT - 1);
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_in[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (!ack_sync && found) begin
        state_d = REQ_HI;
        ptr_d   = PW'((int'(win) + 1) % NUM_REQ);
        data_d  = data_in[int'(win)*DATA_W +: DATA_W];
        grant_d = NUM_REQ'(1) << win;
      end
      REQ_HI: if (ack_sync) state_d = REQ_LO;
        else if (tmo) begin
          state_d = ABORT;
          err_d   = 1'b1;
        end
      REQ_LO: if (!ack_sync) begin
          state_d = IDLE;
          done_d  = grant_q;
          grant_d = '0;
        end else if (tmo) begin
          state_d = ABORT;
          err_d   = 1'b1;
        end
      ABORT: if (!ack_sync) begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // the wait counter restarts on every state change and only runs while a handshake phase is pending
    cnt_d = (state_d != state_q || !(state_q inside {REQ_HI, REQ_LO})) ? '0
          : cnt_q + 16'(cnt_q != 16'hFFFF);
  end
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      xreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      xreq_q  <= state_d == REQ_HI;
    end
  end
  assign xfer_req  = xreq_q;
  assign xfer_data = data_q;
  assign grant_out = grant_q;
  assign done_out  = done_q;
  assign err_out   = err_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// tb_cdc_hs_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_cdc_hs_arbiter;
  localparam int N = 4, W = 8, TO = 10;
  logic clk = 1'b0, rst_n = 1'b1, ack = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dat = '0;
  logic xfer_req, err_out, busy;
  logic [W-1:0] xfer_data;
  logic [N-1:0] grant_out, done_out;
  int vecs = 0, errs = 0;
  bit chk_en = 1'b0;
  bit m_busy = 0, m_acked = 0, m_abort = 0, m_err = 0;
  int m_wait = 0, m_ptr = 0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] m_grant = '0, m_done = '0;
  always #5 clk = ~clk;
  cdc_hs_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk_src(clk), .rst_n(rst_n), .req_in(req), .data_in(dat), .ack_sync(ack),
    .xfer_req(xfer_req), .xfer_data(xfer_data), .grant_out(grant_out),
    .done_out(done_out), .err_out(err_out), .busy(busy)
  );
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic hs();
    ack = 1'b1;
    for (int c = 0; c < 20 && xfer_req; c++) tick();
    ack = 1'b0;
    for (int c = 0; c < 20 && busy; c++) tick();
  endtask
  // one transfer at a time: grant, wait for ack rise, wait for ack fall, or give up after TO cycles in a phase
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_acked <= 0; m_abort <= 0; m_err <= 0;
      m_wait <= 0; m_ptr <= 0; m_data <= '0; m_grant <= '0; m_done <= '0;
    end else begin
      m_done <= '0;
      m_err  <= 0;
      if (!m_busy) begin
        if (!ack && req != '0) begin
          m_busy <= 1; m_acked <= 0; m_abort <= 0; m_wait <= 0;
          m_ptr   <= (pick(req, m_ptr) + 1) % N;
          m_grant <= N'(1 << pick(req, m_ptr));
          m_data  <= dat[pick(req, m_ptr)*W +: W];
        end
      end else if (m_abort) begin
        if (!ack) begin
          m_busy <= 0; m_grant <= '0;
        end
      end else if (!m_acked && ack) begin
        m_acked <= 1; m_wait <= 0;
      end else if (m_acked && !ack) begin
        m_busy <= 0; m_done <= m_grant; m_grant <= '0;
      end else begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 == TO) begin
          m_abort <= 1; m_err <= 1;
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("xfer_req", xfer_req, m_busy && !m_acked && !m_abort);
    chk("xfer_data", xfer_data, m_data);
    chk("grant_out", grant_out, m_grant);
    chk("done_out", done_out, m_done);
    chk("err_out", err_out, m_err);
    chk("busy", busy, m_busy);
  end
  initial begin
    int n, r;
    bit stuck;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_grant", grant_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", xfer_data, 0);
    rst_n = 1'b1;
    tick();
    req = 4'b0001;
    dat = 32'h000000A5;
    tick();
    chk("single_grant", grant_out, 1);
    chk("single_data", xfer_data, 8'hA5);
    chk("single_req", xfer_req, 1);
    req = '0;
    tick();
    tick();
    ack = 1'b1;
    tick();
    chk("single_req_drop", xfer_req, 0);
    tick();
    tick();
    ack = 1'b0;
    tick();
    chk("single_done", done_out, 1);
    chk("single_model_done", m_done, 1);
    chk("single_busy", busy, 0);
    tick();
    chk("single_done_pulse", done_out, 0);
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 20 && grant_out == '0; c++) tick();
      chk("fair_grant", grant_out, 32'(1 << (k % 4)));
      hs();
    end
    req = '0;
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    n = 0;
    for (; xfer_req && n < 50; n++) tick();
    chk("timeout_cycles", n, TO);
    chk("timeout_err", err_out, 1);
    chk("timeout_nodone", done_out, 0);
    tick();
    chk("timeout_err_pulse", err_out, 0);
    chk("timeout_idle", busy, 0);
    rst_n = 1'b0;
    ack = 1'b1;
    req = 4'b0010;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("stale_nogrant", grant_out, 0);
    ack = 1'b0;
    tick();
    chk("stale_grant", grant_out, 4'b0010);
    req = '0;
    hs();
    do_reset();
    dat = 32'h44332211;
    req = 4'b0100;
    tick();
    chk("mid_data", xfer_data, 8'h33);
    req = '0;
    ack = 1'b1;
    tick();
    chk("mid_reqlo", xfer_req, 0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", xfer_data, 0);
    tick();
    ack = 1'b0;
    rst_n = 1'b1;
    req = 4'hF;
    tick();
    chk("mid_restart", grant_out, 4'b0001);
    req = '0;
    hs();
    req = 4'b0100;
    tick();
    chk("drop_grant", grant_out, 4'b0100);
    req = '0;
    tick();
    tick();
    hs();
    chk("drop_done", done_out, 4'b0100);
    stuck = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = $urandom_range(0, 399) != 0;
      if ($urandom_range(0, 149) == 0) stuck = !stuck;
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      dat = $urandom;
      r = int'($urandom_range(0, 99));
      if (r < 4) ack = !ack;
      else if (!stuck && r < 50) ack = xfer_req;
    end
    rst_n = 1'b1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
